// File: rtl/bus_resp.sv
// bus_resp: single-outstanding byte-bus responder backed by an internal byte RAM.
// Each accepted request is serviced WAIT_STATES+1 edges after acceptance. The
// response is held until the initiator takes it.
// Optional feature macro: BUS_RESP_ROM_EN. When it is defined, the low ROM_BYTES
// are write-protected and preloaded with a fixed pattern.
module bus_resp #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 1,
  parameter int ROM_BYTES   = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] ROM_LIMIT = (ADDR_W+1)'(ROM_BYTES);
  localparam logic [3:0]      WAIT_CNT  = 4'(WAIT_STATES);
`ifdef BUS_RESP_ROM_EN
  localparam bit ROM_EN = 1'b1;
`else
  localparam bit ROM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_data_q;

  logic                access;     // access edge: leaving WAIT
  logic                rsp_clear;  // response handshake edge
  logic                in_range;
  logic                protect;
  logic                access_err;
  logic                mem_we;
  logic                mem_re;
  logic [IDX_W-1:0]    mem_idx;

  logic [DATA_W-1:0]   mem_q [MEM_BYTES];

`ifdef BUS_RESP_ROM_EN
  // Preload the protected low region with a fixed pattern.
  initial begin
    for (int i = 0; i < ROM_BYTES && i < MEM_BYTES; i++) begin
      mem_q[i] = DATA_W'(i);
    end
  end
`endif

  // Full-width unsigned compare, so high addresses never alias onto the RAM.
  assign in_range   = ({1'b0, addr_q} < MEM_LIMIT);
  assign protect    = ROM_EN && we_q && ({1'b0, addr_q} < ROM_LIMIT);
  assign access_err = !in_range || protect;
  assign mem_idx    = addr_q[IDX_W-1:0];
  assign mem_we     = access && we_q && !access_err;
  assign mem_re     = access && !we_q && !access_err;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    access      = 1'b0;
    rsp_clear   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          data_d  = req_data;
          cnt_d   = WAIT_CNT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = access_err;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_clear   = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and request-latch registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Registered RAM read port; zero for writes, errors and after the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
    end else if (mem_re) begin
      rsp_data_q <= mem_q[mem_idx];
    end else if (access || rsp_clear) begin
      rsp_data_q <= '0;
    end
  end

  // RAM write port; a write due on a reset edge is suppressed.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[mem_idx] <= data_q;
    end
  end

endmodule

// File: tb/tb_bus_resp.sv
// tb_bus_resp: directed checks of bus_resp (default parameters, WAIT_STATES=1).
// Define BUS_RESP_ROM_EN to also run the write-protect steps.
module tb_bus_resp;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [16:0] req_addr;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] rd;
  logic       er;
  logic [7:0] rom_val;

  bus_resp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction with rsp_ready high; checks latency and handshake.
  task automatic transact(input string tag, input logic we, input logic [16:0] addr,
                          input logic [7:0] wdata, output logic [7:0] rdata, output logic err);
    int lat;
    lat = 0;
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_data  = wdata;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    req_data  = 8'h00;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (rsp_valid) lat = i;
    end
    check({tag, ".latency"}, 32'(lat), 32'd2);
    rdata = rsp_data;
    err   = rsp_err;
    check({tag, ".busy"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".done_data"}, 32'(rsp_data), 32'd0);
    check({tag, ".done_ready"}, 32'(req_ready), 32'd1);
    $display("[TB] %s we=%0d addr=%05h wdata=%02h -> data=%02h err=%0d", tag, we, addr, wdata, rdata, err);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    rsp_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_data", 32'(rsp_data), 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Write then read back
    transact("wr400", 1'b1, 17'h00400, 8'hA5, rd, er);
    check("wr400.data", 32'(rd), 32'h00);
    check("wr400.err", 32'(er), 32'd0);
    transact("rd400", 1'b0, 17'h00400, 8'h00, rd, er);
    check("rd400.data", 32'(rd), 32'hA5);
    check("rd400.err", 32'(er), 32'd0);

    // Range boundaries and no aliasing
    transact("wr000", 1'b1, 17'h00000, 8'h3C, rd, er);
    check("wr000.err", 32'(er), 32'd0);
    transact("wrFFF", 1'b1, 17'h00FFF, 8'h5A, rd, er);
    check("wrFFF.err", 32'(er), 32'd0);
    transact("rd10000", 1'b0, 17'h10000, 8'h00, rd, er);
    check("rd10000.data", 32'(rd), 32'h00);
    check("rd10000.err", 32'(er), 32'd1);
    transact("wr10000", 1'b1, 17'h10000, 8'hFF, rd, er);
    check("wr10000.data", 32'(rd), 32'h00);
    check("wr10000.err", 32'(er), 32'd1);
    transact("wr1000", 1'b1, 17'h01000, 8'hEE, rd, er);
    check("wr1000.err", 32'(er), 32'd1);
    transact("rd1000", 1'b0, 17'h01000, 8'h00, rd, er);
    check("rd1000.data", 32'(rd), 32'h00);
    check("rd1000.err", 32'(er), 32'd1);
    transact("rd000", 1'b0, 17'h00000, 8'h00, rd, er);
    check("rd000.data", 32'(rd), 32'h3C);
    check("rd000.err", 32'(er), 32'd0);
    transact("rdFFF", 1'b0, 17'h00FFF, 8'h00, rd, er);
    check("rdFFF.data", 32'(rd), 32'h5A);
    check("rdFFF.err", 32'(er), 32'd0);

    // Back-pressure: response held while rsp_ready is low; requests ignored
    transact("wr020", 1'b1, 17'h00020, 8'hC7, rd, er);
    check("wr020.err", 32'(er), 32'd0);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 17'h00020;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("hold.rise_valid", 32'(rsp_valid), 32'd1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_data  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold.valid", 32'(rsp_valid), 32'd1);
      check("hold.data", 32'(rsp_data), 32'hC7);
      check("hold.req_ready", 32'(req_ready), 32'd0);
    end
    $display("[TB] hold addr=00020 data=%02h held 5 cycles", rsp_data);
    rsp_ready = 1'b1;
    tick();
    check("hold.release_valid", 32'(rsp_valid), 32'd0);
    check("hold.release_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    req_we    = 1'b0;
    transact("rd020", 1'b0, 17'h00020, 8'h00, rd, er);
    check("rd020.data", 32'(rd), 32'hC7);

    // Reset on the access edge cancels the pending write
    transact("wr010", 1'b1, 17'h00010, 8'h11, rd, er);
    check("wr010.err", 32'(er), 32'd0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 17'h00010;
    req_data  = 8'h77;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid.req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    $display("[TB] reset during write addr=00010 data=77");
    transact("rd010", 1'b0, 17'h00010, 8'h00, rd, er);
    check("rd010.data", 32'(rd), 32'h11);
    check("rd010.err", 32'(er), 32'd0);

`ifdef BUS_RESP_ROM_EN
    // Write protection of the low ROM region
    transact("rdFF", 1'b0, 17'h000FF, 8'h00, rom_val, er);
    check("rdFF.err", 32'(er), 32'd0);
    transact("wrFF", 1'b1, 17'h000FF, 8'h99, rd, er);
    check("wrFF.err", 32'(er), 32'd1);
    transact("rdFF2", 1'b0, 17'h000FF, 8'h00, rd, er);
    check("rdFF2.data", 32'(rd), 32'(rom_val));
    transact("wr100", 1'b1, 17'h00100, 8'h99, rd, er);
    check("wr100.err", 32'(er), 32'd0);
    transact("rd100", 1'b0, 17'h00100, 8'h00, rd, er);
    check("rd100.data", 32'(rd), 32'h99);
`else
    rom_val = 8'h00;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
